// File: rtl/custom_fifo_uart_rx_valid_ready.sv
// -----------------------------------------------------------------------------
// custom_fifo_uart_rx_valid_ready
//
// Receive-side packer for the UART path. WIDTH-bit words arrive one at a time
// over a valid/ready stream. Each group of DEPTH consecutive words is assembled
// into one packed block. The block is then offered downstream over a second
// valid/ready handshake. Element 0 of a block is the first word received.
//
// The design has two stages:
//   - fill stage   : word buffer, write pointer, and a fill_full flag. The flag
//                    is set when a completed block is parked because the
//                    output stage is still occupied.
//   - output stage : block register driving down_data, plus down_valid.
// One finished block can wait in the output stage while the next block fills.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous reset, active-high
//   up_valid   in   upstream word valid
//   up_ready   out  packer can accept a word this cycle (registered state only)
//   up_data    in   upstream word, WIDTH bits
//   down_valid out  a complete block is held on down_data
//   down_ready in   consumer accepts the block this cycle
//   down_data  out  packed block, element k = k-th word received
// -----------------------------------------------------------------------------
module custom_fifo_uart_rx_valid_ready #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        up_valid,
    output logic                        up_ready,
    input  logic [WIDTH-1:0]            up_data,
    output logic                        down_valid,
    input  logic                        down_ready,
    output logic [DEPTH-1:0][WIDTH-1:0] down_data
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [DEPTH-1:0][WIDTH-1:0] fill_q, fill_d;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic                        fill_full_q, fill_full_d;
    logic [DEPTH-1:0][WIDTH-1:0] out_q, out_d;
    logic                        down_valid_q, down_valid_d;

    logic                        up_fire;
    logic                        down_fire;
    logic                        out_free;
    logic                        is_last;
    logic [DEPTH-1:0][WIDTH-1:0] block;

    // up_ready depends on registered state only, so there is no combinational
    // path from up_valid or down_ready.
    assign up_ready   = ~fill_full_q;
    assign down_valid = down_valid_q;
    assign down_data  = out_q;

    assign up_fire   = up_valid & up_ready;
    assign down_fire = down_valid_q & down_ready;
    assign out_free  = ~down_valid_q | down_ready;
    assign is_last   = (wr_ptr_q == LAST_PTR);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        fill_d       = fill_q;
        wr_ptr_d     = wr_ptr_q;
        fill_full_d  = fill_full_q;
        out_d        = out_q;
        down_valid_d = down_valid_q;

        // The block as it would look with the incoming word as the last element.
        block            = fill_q;
        block[DEPTH-1]   = up_data;

        // A consumed block empties the output stage. A load later in this
        // block overrides this, so back-to-back blocks have no bubble.
        if (down_fire) begin
            down_valid_d = 1'b0;
        end

        if (fill_full_q && out_free) begin
            // A parked block moves to the output stage. up_ready is low in
            // this state, so no word can arrive in the same cycle.
            out_d        = fill_q;
            down_valid_d = 1'b1;
            fill_full_d  = 1'b0;
        end else if (up_fire) begin
            if (is_last) begin
                wr_ptr_d = '0;
                if (out_free) begin
                    out_d        = block;
                    down_valid_d = 1'b1;
                end else begin
                    fill_d      = block;
                    fill_full_d = 1'b1;
                end
            end else begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (wr_ptr_q == PTR_W'(k)) begin
                        fill_d[k] = up_data;
                    end
                end
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments, so all
    // registers sample their inputs at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            fill_full_q  <= 1'b0;
            down_valid_q <= 1'b0;
            // NOTE: both block storages are cleared on reset. This gives a
            // known down_data after reset and discards any partial block.
            fill_q       <= '0;
            out_q        <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            fill_full_q  <= fill_full_d;
            down_valid_q <= down_valid_d;
            fill_q       <= fill_d;
            out_q        <= out_d;
        end
    end

endmodule
